// File: rtl/aes192_ctr_sequencer.sv
// CTR-mode sequencer for an AES-192 core: builds {nonce,ctr}, pulses start, XORs keystream into one block.
// Optional byte masking (din_keep/dout_keep) is compiled in when AES_CTR_BYTE_MASK_EN is defined.
module aes192_ctr_sequencer #(
  parameter int TIMEOUT_CYC = 64,
  parameter int CTR_W       = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cfg_load,
  output logic               cfg_ready,
  input  logic [191:0]       cfg_key,
  input  logic [127-CTR_W:0] cfg_nonce,
  input  logic [CTR_W-1:0]   cfg_ctr_init,
  input  logic               din_valid,
  output logic               din_ready,
  input  logic [127:0]       din_data,
  input  logic               din_last,
`ifdef AES_CTR_BYTE_MASK_EN
  input  logic [15:0]        din_keep,
  output logic [15:0]        dout_keep,
`endif
  output logic               dout_valid,
  input  logic               dout_ready,
  output logic [127:0]       dout_data,
  output logic               dout_last,
  output logic               core_start,
  output logic [127:0]       core_state,
  output logic [191:0]       core_key,
  input  logic [127:0]       core_out,
  input  logic               core_out_valid,
  output logic               err_timeout,
  output logic               ctr_wrap,
  output logic [2:0]         dbg_state
);

  // Handshakes: a transfer happens on a cycle where valid & ready are both high; a producer
  // holds valid and its payload stable until that cycle, and ready never waits on a later valid.

  localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_ARM   = 3'd2,
    S_WAIT  = 3'd3,
    S_OUT   = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic               configured_q;
  logic [191:0]       key_q;
  logic [127-CTR_W:0] nonce_q;
  logic [CTR_W-1:0]   ctr_q;
  logic [127:0]       data_q;
  logic               last_q;
  logic [TMO_W-1:0]   tmo_q;
  logic               cfg_fire, din_fire, ks_fire, tmo_hit, tmo_abort;
  logic [127:0]       ks_data;

  assign cfg_fire = (state_q == S_IDLE) & cfg_load;
  assign din_fire = din_valid & din_ready;
  assign ks_fire  = (state_q == S_WAIT) & core_out_valid;
  assign tmo_hit  = (tmo_q == TMO_W'(TIMEOUT_CYC - 1));

`ifdef AES_CTR_BYTE_MASK_EN
  logic [15:0] keep_q;
  always_comb begin
    ks_data = data_q ^ core_out;
    for (int i = 0; i < 16; i++) begin
      if (!keep_q[i]) ks_data[8*i +: 8] = 8'h00;
    end
  end
`else
  assign ks_data = data_q ^ core_out;
`endif

  always_comb begin
    state_d    = state_q;
    cfg_ready  = 1'b0;
    din_ready  = 1'b0;
    core_start = 1'b0;
    tmo_abort  = 1'b0;
    case (state_q)
      S_IDLE: begin
        cfg_ready = 1'b1;
        // A config load in the same cycle takes priority over new data.
        din_ready = configured_q & ~cfg_load;
        if (din_valid & configured_q & ~cfg_load) state_d = S_ISSUE;
      end
      S_ISSUE: begin
        core_start = 1'b1;
        state_d    = S_ARM;
      end
      S_ARM: begin
        // The core drops out_valid once it has seen the start edge.
        if (!core_out_valid) state_d = S_WAIT;
        else if (tmo_hit) begin
          tmo_abort = 1'b1;
          state_d   = S_IDLE;
        end
      end
      S_WAIT: begin
        if (core_out_valid) state_d = S_OUT;
        else if (tmo_hit) begin
          tmo_abort = 1'b1;
          state_d   = S_IDLE;
        end
      end
      S_OUT: begin
        if (dout_ready) begin
          din_ready = ~last_q;
          state_d   = (din_valid & ~last_q) ? S_ISSUE : S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      configured_q <= 1'b0;
      key_q        <= '0;
      nonce_q      <= '0;
      ctr_q        <= '0;
      data_q       <= '0;
      last_q       <= 1'b0;
      tmo_q        <= '0;
      dout_data    <= '0;
      dout_last    <= 1'b0;
      err_timeout  <= 1'b0;
      ctr_wrap     <= 1'b0;
`ifdef AES_CTR_BYTE_MASK_EN
      keep_q       <= '0;
      dout_keep    <= '0;
`endif
    end else begin
      state_q <= state_d;
      if (cfg_fire) begin
        key_q        <= cfg_key;
        nonce_q      <= cfg_nonce;
        ctr_q        <= cfg_ctr_init;
        configured_q <= 1'b1;
        err_timeout  <= 1'b0;
        ctr_wrap     <= 1'b0;
      end
      if (din_fire) begin
        data_q <= din_data;
        last_q <= din_last;
`ifdef AES_CTR_BYTE_MASK_EN
        keep_q <= din_keep;
`endif
      end
      if (state_q == S_ISSUE) tmo_q <= '0;
      else if (state_q == S_ARM || state_q == S_WAIT) tmo_q <= tmo_q + 1'b1;
      if (tmo_abort) err_timeout <= 1'b1;
      // The whole keystream block is consumed even when bytes are masked off.
      if (ks_fire) begin
        dout_data <= ks_data;
        dout_last <= last_q;
        ctr_q     <= ctr_q + 1'b1;
        if (&ctr_q) ctr_wrap <= 1'b1;
`ifdef AES_CTR_BYTE_MASK_EN
        dout_keep <= keep_q;
`endif
      end
    end
  end

  assign dout_valid = (state_q == S_OUT);
  assign core_state = {nonce_q, ctr_q};
  assign core_key   = key_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_aes192_ctr_sequencer.sv
// Bench for aes192_ctr_sequencer: behavioural core stand-in, directed blocks, scoreboard monitors.
// Define AES_CTR_BYTE_MASK_EN to also exercise the byte-mask ports.
module tb_aes192_ctr_sequencer;
  localparam int CTR_W       = 32;
  localparam int NW          = 128 - CTR_W;
  localparam int TIMEOUT_CYC = 64;
  localparam int CORE_LAT    = 26;
  localparam int EW          = 16 + 1 + 128;

  localparam logic [191:0] KEY1   = 192'h000102030405060708090a0b0c0d0e0f1011121314151617;
  localparam logic [191:0] KEY2   = 192'hfedcba98765432100f1e2d3c4b5a69788796a5b4c3d2e1f0;
  localparam logic [NW-1:0] NONCE2 = 96'hdeadbeef0123456789abcdef;
  localparam logic [NW-1:0] NONCE3 = 96'h0000111122223333aaaa5555;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic               cfg_load = 1'b0;
  logic               cfg_ready;
  logic [191:0]       cfg_key = '0;
  logic [NW-1:0]      cfg_nonce = '0;
  logic [CTR_W-1:0]   cfg_ctr_init = '0;
  logic               din_valid = 1'b0;
  logic               din_ready;
  logic [127:0]       din_data = '0;
  logic               din_last = 1'b0;
  logic               dout_valid;
  logic               dout_ready = 1'b1;
  logic [127:0]       dout_data;
  logic               dout_last;
  logic               core_start;
  logic [127:0]       core_state;
  logic [191:0]       core_key;
  logic [127:0]       core_out = '0;
  logic               core_out_valid = 1'b1;
  logic               err_timeout;
  logic               ctr_wrap;
  logic [2:0]         dbg_state;
`ifdef AES_CTR_BYTE_MASK_EN
  logic [15:0]        din_keep = 16'hffff;
  logic [15:0]        dout_keep;
`endif

  aes192_ctr_sequencer #(.TIMEOUT_CYC(TIMEOUT_CYC), .CTR_W(CTR_W)) dut (
    .clk(clk), .rst(rst),
    .cfg_load(cfg_load), .cfg_ready(cfg_ready), .cfg_key(cfg_key), .cfg_nonce(cfg_nonce),
    .cfg_ctr_init(cfg_ctr_init),
    .din_valid(din_valid), .din_ready(din_ready), .din_data(din_data), .din_last(din_last),
`ifdef AES_CTR_BYTE_MASK_EN
    .din_keep(din_keep), .dout_keep(dout_keep),
`endif
    .dout_valid(dout_valid), .dout_ready(dout_ready), .dout_data(dout_data), .dout_last(dout_last),
    .core_start(core_start), .core_state(core_state), .core_key(core_key),
    .core_out(core_out), .core_out_valid(core_out_valid),
    .err_timeout(err_timeout), .ctr_wrap(ctr_wrap), .dbg_state(dbg_state)
  );

  int n_checks = 0;
  int n_errors = 0;
  logic [EW-1:0]  exp_q[$];
  logic [127:0]   start_q[$];
  logic [191:0]   cur_key = '0;
  logic [NW-1:0]  cur_nonce = '0;
  logic [CTR_W-1:0] exp_ctr = '0;
  logic           core_dead = 1'b0;

  // Stand-in keystream: simple but depends on every state and key bit.
  function automatic logic [127:0] ks_f(input logic [127:0] st, input logic [191:0] k);
    return st ^ k[127:0] ^ {k[191:128], k[191:128]};
  endfunction

  function automatic logic [127:0] mask_f(input logic [127:0] x, input logic [15:0] k);
    logic [127:0] r;
    r = x;
    for (int i = 0; i < 16; i++) if (!k[i]) r[8*i +: 8] = 8'h00;
    return r;
  endfunction

  task automatic check(input string name, input logic [191:0] act, input logic [191:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Core model: samples the start edge, drops out_valid, raises it CORE_LAT+1 edges later.
  logic start_d = 1'b0;
  int   core_cnt = 0;
  always @(posedge clk) begin
    start_d <= core_start;
    if (core_start && !start_d) begin
      core_cnt       <= CORE_LAT + 1;
      core_out_valid <= 1'b0;
    end else if (core_cnt > 0) begin
      core_cnt <= core_cnt - 1;
      if (core_cnt == 1 && !core_dead) begin
        core_out_valid <= 1'b1;
        core_out       <= ks_f(core_state, core_key);
      end
    end
  end

  // Scoreboard monitors
  int since_start = 100;
  always @(negedge clk) begin
    if (!rst) begin
      if (dout_valid && dout_ready) begin
        check("dout_expected", 192'(exp_q.size() != 0), 192'(1));
        if (exp_q.size() != 0) begin
          check("dout_data", 192'(dout_data), 192'(exp_q[0][127:0]));
          check("dout_last", 192'(dout_last), 192'(exp_q[0][128]));
`ifdef AES_CTR_BYTE_MASK_EN
          check("dout_keep", 192'(dout_keep), 192'(exp_q[0][144:129]));
`endif
          void'(exp_q.pop_front());
        end
      end
      if (core_start) begin
        check("start_expected", 192'(start_q.size() != 0), 192'(1));
        check("start_gap", 192'(since_start >= 3), 192'(1));
        if (start_q.size() != 0) begin
          check("core_state", 192'(core_state), 192'(start_q[0]));
          void'(start_q.pop_front());
        end
        since_start <= 0;
      end else if (since_start < 1000) begin
        since_start <= since_start + 1;
      end
    end
  end

  // Driver tasks
  task automatic push_block(input logic [127:0] d, input logic l, input logic [15:0] k,
                            input logic expect_out);
    start_q.push_back({cur_nonce, exp_ctr});
    if (expect_out) begin
      exp_q.push_back({k, l, mask_f(d ^ ks_f({cur_nonce, exp_ctr}, cur_key), k)});
      exp_ctr = exp_ctr + 1'b1;
    end
  endtask

  task automatic send(input logic [127:0] d, input logic l, input logic [15:0] k,
                      input logic expect_out);
    int budget;
    budget = 200;
    din_valid = 1'b1;
    din_data  = d;
    din_last  = l;
`ifdef AES_CTR_BYTE_MASK_EN
    din_keep  = k;
`endif
    @(negedge clk);
    while (!din_ready && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    if (!din_ready) check("din_accept", 192'(din_ready), 192'(1));
    else push_block(d, l, k, expect_out);
    @(posedge clk); #1;
    din_valid = 1'b0;
  endtask

  task automatic configure(input logic [191:0] k, input logic [NW-1:0] n, input logic [CTR_W-1:0] c);
    @(posedge clk); #1;
    cfg_key      = k;
    cfg_nonce    = n;
    cfg_ctr_init = c;
    cfg_load     = 1'b1;
    @(negedge clk);
    check("cfg_ready", 192'(cfg_ready), 192'(1));
    @(posedge clk); #1;
    cfg_load  = 1'b0;
    cur_key   = k;
    cur_nonce = n;
    exp_ctr   = c;
  endtask

  task automatic wait_drain();
    int budget;
    budget = 400;
    while ((exp_q.size() != 0 || dbg_state != 3'd0) && budget > 0) begin
      @(posedge clk); #1;
      budget--;
    end
    check("drain_queue", 192'(exp_q.size()), 192'(0));
    check("drain_idle", 192'(dbg_state), 192'(0));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [127:0] held;

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_ctrl", 192'({cfg_ready, din_ready, dout_valid, core_start, err_timeout, ctr_wrap, dout_last}),
          192'(7'b1000000));
    check("reset_key", 192'(core_key), 192'(0));
    check("reset_state", 192'(core_state), 192'(0));
    check("reset_dout", 192'(dout_data), 192'(0));
    check("reset_fsm", 192'(dbg_state), 192'(0));

    // single block of zeros, key 00..17, nonce 0, ctr 1
    configure(KEY1, '0, 32'd1);
    check("cfg_key_out", 192'(core_key), 192'(KEY1));
    check("cfg_state_out", 192'(core_state), 192'({96'h0, 32'd1}));
    send(128'h0, 1'b1, 16'hffff, 1'b1);
    n = 0;
    while (!dout_valid && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check("latency", 192'(n), 192'(3 + CORE_LAT));
    check("ctr_after_one", 192'(core_state), 192'({96'h0, 32'd2}));
    wait_drain();

    // config and data offered together, then four chained blocks
    @(posedge clk); #1;
    cfg_key = KEY1; cfg_nonce = '0; cfg_ctr_init = 32'd1; cfg_load = 1'b1;
    din_valid = 1'b1; din_data = 128'h11111111222222223333333344444444; din_last = 1'b0;
    @(negedge clk);
    check("cfg_wins_din", 192'(din_ready), 192'(0));
    @(posedge clk); #1;
    cfg_load = 1'b0;
    cur_key = KEY1; cur_nonce = '0; exp_ctr = 32'd1;
    send(128'h11111111222222223333333344444444, 1'b0, 16'hffff, 1'b1);
    send(128'h0123456789abcdef0123456789abcdef, 1'b0, 16'hffff, 1'b1);
    send(128'hffffffffffffffffffffffffffffffff, 1'b0, 16'hffff, 1'b1);
    send(128'ha5a5a5a55a5a5a5ac3c3c3c33c3c3c3c, 1'b1, 16'hffff, 1'b1);
    wait_drain();
    check("ctr_after_four", 192'(core_state), 192'({96'h0, 32'd5}));

    // counter wrap
    configure(KEY2, NONCE2, 32'hffffffff);
    check("wrap_clear", 192'(ctr_wrap), 192'(0));
    send(128'hcafef00dcafef00dcafef00dcafef00d, 1'b0, 16'hffff, 1'b1);
    send(128'h00000000000000000000000000000001, 1'b1, 16'hffff, 1'b1);
    wait_drain();
    check("wrap_set", 192'(ctr_wrap), 192'(1));
    check("wrap_nonce", 192'(core_state), 192'({NONCE2, 32'h1}));

    // core never answers
    configure(KEY1, NONCE3, 32'h10);
    check("wrap_cleared_by_cfg", 192'(ctr_wrap), 192'(0));
    core_dead = 1'b1;
    send(128'hdeaddeaddeaddeaddeaddeaddeaddead, 1'b1, 16'hffff, 1'b0);
    n = 0;
    while (!err_timeout && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    check("timeout_cycles", 192'(n), 192'(TIMEOUT_CYC + 1));
    check("timeout_idle", 192'({dbg_state, dout_valid}), 192'(0));
    check("timeout_ctr_kept", 192'(core_state), 192'({NONCE3, 32'h10}));
    core_dead = 1'b0;
    send(128'h13579bdf2468ace013579bdf2468ace0, 1'b1, 16'hffff, 1'b1);
    wait_drain();
    check("timeout_sticky", 192'(err_timeout), 192'(1));

    // downstream stall, chained accept, then reset during WAIT
    configure(KEY2, NONCE2, 32'h100);
    check("timeout_cleared_by_cfg", 192'(err_timeout), 192'(0));
    dout_ready = 1'b0;
    held = 128'h0f0f0f0ff0f0f0f00f0f0f0ff0f0f0f0 ^ ks_f({NONCE2, 32'h100}, KEY2);
    send(128'h0f0f0f0ff0f0f0f00f0f0f0ff0f0f0f0, 1'b0, 16'hffff, 1'b1);
    n = 0;
    while (!dout_valid && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    din_valid = 1'b1; din_data = 128'h55555555aaaaaaaa55555555aaaaaaaa; din_last = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("stall_hold", 192'({dout_valid, din_ready, core_start, dout_data}), 192'({3'b100, held}));
    end
    @(posedge clk); #1;
    dout_ready = 1'b1;
    @(negedge clk);
    check("chain_din_ready", 192'(din_ready), 192'(1));
    push_block(128'h55555555aaaaaaaa55555555aaaaaaaa, 1'b0, 16'hffff, 1'b1);
    @(posedge clk); #1;
    din_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check("pre_reset_wait", 192'(dbg_state), 192'(3));
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q.delete();
    start_q.delete();
    @(negedge clk);
    check("midrst_ctrl", 192'({cfg_ready, din_ready, dout_valid, core_start, err_timeout, ctr_wrap}),
          192'(6'b100000));
    check("midrst_fsm", 192'(dbg_state), 192'(0));
    check("midrst_key", 192'(core_key), 192'(0));
    repeat (40) @(posedge clk);
    #1;
    check("midrst_quiet", 192'({dout_valid, dbg_state}), 192'(0));

`ifdef AES_CTR_BYTE_MASK_EN
    configure(KEY1, NONCE2, 32'h7);
    send(128'hffeeddccbbaa99887766554433221100, 1'b1, 16'h00ff, 1'b1);
    wait_drain();
    check("mask_ctr", 192'(core_state), 192'({NONCE2, 32'h8}));
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
